// File: rtl/ex_mem_flag_stage.sv
// EX/MEM pipeline register with the architectural N/Z/V flag register,
// same-cycle flag forwarding and branch condition evaluation for ID.
module ex_mem_flag_stage #(
   parameter int         DATA_W    = 16,
   parameter logic [2:0] RST_FLAGS = 3'b000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              flush,
   input  logic              ex_valid,
   input  logic [3:0]        ex_opcode,
   input  logic [DATA_W-1:0] ex_alu_result,
   input  logic [2:0]        ex_alu_flags,
   input  logic [DATA_W-1:0] ex_store_data,
   input  logic [3:0]        ex_rd,
   input  logic              ex_reg_write,
   input  logic              ex_mem_read,
   input  logic              ex_mem_write,
   input  logic [2:0]        id_cond,
   output logic              mem_valid,
   output logic [3:0]        mem_opcode,
   output logic [DATA_W-1:0] mem_alu_result,
   output logic [DATA_W-1:0] mem_store_data,
   output logic [3:0]        mem_rd,
   output logic              mem_reg_write,
   output logic              mem_mem_read,
   output logic              mem_mem_write,
   output logic [2:0]        flags_q,
   output logic [2:0]        flags_fwd,
   output logic              cond_true
);

   logic       acc;
   logic       upd_all;
   logic       upd_z;
   logic       upd;
   logic [2:0] flags_new;
   logic       n_f;
   logic       z_f;
   logic       v_f;

   assign acc = ex_valid & ~stall & ~flush;

   always_comb begin
      upd_all = 1'b0;
      upd_z   = 1'b0;
      unique case (ex_opcode)
         4'b0000, 4'b0001: upd_all = 1'b1;
         4'b0010, 4'b0100,
         4'b0101, 4'b0110: upd_z   = 1'b1;
         default: ;
      endcase
   end

   // Z-only ops keep N and V from the register
   always_comb begin
      flags_new = flags_q;
      if (upd_all)
         flags_new = ex_alu_flags;
      else if (upd_z)
         flags_new = {flags_q[2], ex_alu_flags[1], flags_q[0]};
   end

   assign upd       = acc & (upd_all | upd_z);
   assign flags_fwd = upd ? flags_new : flags_q;

   assign n_f = flags_fwd[2];
   assign z_f = flags_fwd[1];
   assign v_f = flags_fwd[0];

   always_comb begin
      cond_true = 1'b0;
      unique case (id_cond)
         3'b000: cond_true = ~z_f;
         3'b001: cond_true = z_f;
         3'b010: cond_true = ~z_f & ~n_f;
         3'b011: cond_true = n_f;
         3'b100: cond_true = z_f | ~n_f;
         3'b101: cond_true = n_f | z_f;
         3'b110: cond_true = v_f;
         3'b111: cond_true = 1'b1;
         default: cond_true = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         flags_q <= RST_FLAGS;
      else if (upd)
         flags_q <= flags_new;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_valid      <= 1'b0;
         mem_opcode     <= '0;
         mem_alu_result <= '0;
         mem_store_data <= '0;
         mem_rd         <= '0;
         mem_reg_write  <= 1'b0;
         mem_mem_read   <= 1'b0;
         mem_mem_write  <= 1'b0;
      end else if (stall) begin
         mem_valid      <= mem_valid;
      end else if (flush) begin
         mem_valid      <= 1'b0;
         mem_opcode     <= '0;
         mem_alu_result <= '0;
         mem_store_data <= '0;
         mem_rd         <= '0;
         mem_reg_write  <= 1'b0;
         mem_mem_read   <= 1'b0;
         mem_mem_write  <= 1'b0;
      end else begin
         // controls of an empty slot must never reach MEM
         mem_valid      <= ex_valid;
         mem_opcode     <= ex_opcode;
         mem_alu_result <= ex_alu_result;
         mem_store_data <= ex_store_data;
         mem_rd         <= ex_rd;
         mem_reg_write  <= ex_reg_write & ex_valid;
         mem_mem_read   <= ex_mem_read & ex_valid;
         mem_mem_write  <= ex_mem_write & ex_valid;
      end
   end

endmodule

// File: tb/tb_ex_mem_flag_stage.sv
// Scoreboard bench for ex_mem_flag_stage: a reference model pushes
// expected MEM/flag state per driven cycle, popped after each edge.
module tb_ex_mem_flag_stage;

   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          stall, flush, ex_valid;
   logic [3:0]    ex_opcode, ex_rd;
   logic [DW-1:0] ex_alu_result, ex_store_data;
   logic [2:0]    ex_alu_flags, id_cond;
   logic          ex_reg_write, ex_mem_read, ex_mem_write;
   logic          mem_valid, mem_reg_write, mem_mem_read, mem_mem_write;
   logic [3:0]    mem_opcode, mem_rd;
   logic [DW-1:0] mem_alu_result, mem_store_data;
   logic [2:0]    flags_q, flags_fwd;
   logic          cond_true;

   ex_mem_flag_stage #(.DATA_W(DW), .RST_FLAGS(3'b000)) dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .ex_valid(ex_valid), .ex_opcode(ex_opcode),
      .ex_alu_result(ex_alu_result), .ex_alu_flags(ex_alu_flags),
      .ex_store_data(ex_store_data), .ex_rd(ex_rd),
      .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
      .ex_mem_write(ex_mem_write), .id_cond(id_cond),
      .mem_valid(mem_valid), .mem_opcode(mem_opcode),
      .mem_alu_result(mem_alu_result), .mem_store_data(mem_store_data),
      .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
      .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
      .flags_q(flags_q), .flags_fwd(flags_fwd), .cond_true(cond_true)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          v;
      logic [3:0]    op;
      logic [DW-1:0] res;
      logic [DW-1:0] sd;
      logic [3:0]    rd;
      logic          rw, mr, mw;
      logic [2:0]    fl;
   } exp_t;

   exp_t q[$];
   exp_t m;
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic ref_cond(input logic [2:0] f,
                                     input logic [2:0] c);
      logic n, z, v;
      n = f[2]; z = f[1]; v = f[0];
      case (c)
         3'd0: return !z;
         3'd1: return z;
         3'd2: return !z && !n;
         3'd3: return n;
         3'd4: return z || !n;
         3'd5: return n || z;
         3'd6: return v;
         default: return 1'b1;
      endcase
   endfunction

   function automatic exp_t zero_state(input logic [2:0] f);
      exp_t e;
      e.v = 0; e.op = 0; e.res = 0; e.sd = 0; e.rd = 0;
      e.rw = 0; e.mr = 0; e.mw = 0; e.fl = f;
      return e;
   endfunction

   // one pipeline cycle: drive, check forwarding, model, edge, compare
   task automatic cyc(input logic v, input logic [3:0] op,
                      input logic [DW-1:0] res, input logic [2:0] af,
                      input logic st, input logic fu,
                      input logic [2:0] c);
      logic       acc, all, zo;
      logic [2:0] fnew, fwd;
      exp_t       e;
      ex_valid = v; ex_opcode = op; ex_alu_result = res;
      ex_alu_flags = af; stall = st; flush = fu; id_cond = c;
      ex_store_data = res ^ 16'h5a5a;
      ex_rd = res[7:4];
      ex_mem_read = (op == 4'b1000);
      ex_mem_write = (op == 4'b1001);
      ex_reg_write = (op != 4'b1001);
      #1;
      acc = v && !st && !fu;
      all = (op == 4'd0) || (op == 4'd1);
      zo = (op == 4'd2) || (op == 4'd4) || (op == 4'd5) || (op == 4'd6);
      fnew = all ? af : zo ? {m.fl[2], af[1], m.fl[0]} : m.fl;
      fwd = (acc && (all || zo)) ? fnew : m.fl;
      chk("flags_fwd", flags_fwd, fwd);
      chk("cond_true", cond_true, ref_cond(fwd, c));
      if (!st) begin
         if (fu) begin
            m = zero_state(m.fl);
         end else begin
            m.v = v; m.op = op; m.res = res; m.sd = ex_store_data;
            m.rd = ex_rd;
            m.rw = ex_reg_write && v;
            m.mr = ex_mem_read && v;
            m.mw = ex_mem_write && v;
         end
      end
      m.fl = fwd;
      q.push_back(m);
      @(posedge clk);
      #1;
      chk("sb_depth", q.size(), 1);
      if (q.size() != 0) begin
         e = q.pop_front();
         chk("mem_valid", mem_valid, e.v);
         chk("mem_opcode", mem_opcode, e.op);
         chk("mem_alu_result", mem_alu_result, e.res);
         chk("mem_store_data", mem_store_data, e.sd);
         chk("mem_rd", mem_rd, e.rd);
         chk("mem_reg_write", mem_reg_write, e.rw);
         chk("mem_mem_read", mem_mem_read, e.mr);
         chk("mem_mem_write", mem_mem_write, e.mw);
         chk("flags_q", flags_q, e.fl);
      end
   endtask

   // asynchronous reset raised between edges, held across a stalled edge
   task automatic do_reset();
      ex_valid = 1; ex_opcode = 4'd0; ex_alu_flags = 3'b111;
      ex_alu_result = 16'hbeef; ex_store_data = 16'h1; ex_rd = 4'd3;
      ex_reg_write = 1; ex_mem_read = 0; ex_mem_write = 0;
      stall = 1; flush = 0; id_cond = 3'b111;
      #3 rst = 1'b1;
      #1;
      m = zero_state(3'b000);
      chk("rst_flags_q", flags_q, 3'b000);
      chk("rst_mem_valid", mem_valid, 1'b0);
      chk("rst_cond_111", cond_true, 1'b1);
      id_cond = 3'b001;
      #1;
      chk("rst_cond_001", cond_true, 1'b0);
      @(posedge clk);
      #1;
      chk("rst_hold_valid", mem_valid, 1'b0);
      chk("rst_hold_result", mem_alu_result, 16'h0);
      chk("rst_hold_flags", flags_q, 3'b000);
      ex_valid = 0; stall = 0;
      rst = 1'b0;
   endtask

   initial begin
      rst = 0; stall = 0; flush = 0; ex_valid = 0; ex_opcode = 0;
      ex_alu_result = 0; ex_alu_flags = 0; ex_store_data = 0; ex_rd = 0;
      ex_reg_write = 0; ex_mem_read = 0; ex_mem_write = 0; id_cond = 0;
      m = zero_state(3'b000);
      @(posedge clk);
      do_reset();
      // Z-only update and non-updating opcode
      cyc(1, 4'd0, 16'h0011, 3'b101, 0, 0, 3'd0);
      cyc(1, 4'd2, 16'h0022, 3'b010, 0, 0, 3'd1);
      chk("zonly_flags", flags_q, 3'b111);
      cyc(1, 4'd3, 16'h0033, 3'b000, 0, 0, 3'd6);
      chk("red_keeps", flags_q, 3'b111);
      // forwarding of SUB flags into the branch condition
      cyc(1, 4'd0, 16'h0044, 3'b100, 0, 0, 3'd3);
      id_cond = 3'b001;
      cyc(1, 4'd1, 16'h0055, 3'b010, 0, 0, 3'd1);
      chk("fwd_next_flags", flags_q, 3'b010);
      // stall for three cycles with ADD in EX
      for (int i = 0; i < 3; i++)
         cyc(1, 4'd0, 16'h1234, 3'b001, 1, 0, 3'd6);
      cyc(1, 4'd0, 16'h1234, 3'b001, 0, 0, 3'd6);
      chk("stall_release_res", mem_alu_result, 16'h1234);
      chk("stall_release_fl", flags_q, 3'b001);
      // flush of an SW, then flush together with stall
      cyc(1, 4'd9, 16'h0abc, 3'b110, 0, 1, 3'd0);
      cyc(1, 4'd8, 16'h0def, 3'b000, 0, 0, 3'd0);
      cyc(1, 4'd0, 16'h0fed, 3'b110, 1, 1, 3'd0);
      cyc(0, 4'd0, 16'h0000, 3'b000, 0, 0, 3'd0);
      // condition sweep with forwarding inactive
      for (int f = 0; f < 5; f++) begin
         logic [2:0] fv;
         case (f)
            0: fv = 3'b000;
            1: fv = 3'b001;
            2: fv = 3'b010;
            3: fv = 3'b100;
            default: fv = 3'b110;
         endcase
         cyc(1, 4'd0, 16'h0100, fv, 0, 0, 3'd7);
         for (int c = 0; c < 8; c++)
            cyc(0, 4'd0, 16'h0000, 3'b000, 0, 0, c[2:0]);
      end
      // random mix of stall, flush and opcodes
      for (int i = 0; i < 60; i++)
         cyc($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
             16'($urandom), 3'($urandom_range(0, 7)),
             $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
             3'($urandom_range(0, 7)));
      // reset while stalled with live state
      cyc(1, 4'd0, 16'h7777, 3'b111, 0, 0, 3'd0);
      do_reset();
      cyc(1, 4'd2, 16'h0001, 3'b010, 0, 0, 3'd1);
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule

// File: doc/ex_mem_flag_stage.md
# ex_mem_flag_stage

EX/MEM boundary of the 16-bit pipelined core, directly downstream of the ALU. It registers the ALU result and the memory and writeback controls into the MEM stage, supporting stall (hold) and flush (bubble). It owns the architectural N/Z/V flag register and applies per-opcode flag-update rules. It also supplies ID-stage branch logic with forwarded flags and a condition-true signal.

## Interface
- DATA_W, 16, width of ALU result and store data
- RST_FLAGS, 3'b000, flag register value after reset, {N,Z,V}

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- stall  in  1  MEM stage busy; hold all registered state
- flush  in  1  replace the incoming EX instruction with a bubble
- ex_valid  in  1  EX slot holds a real instruction
- ex_opcode  in  4  EX instruction opcode
- ex_alu_result  in  DATA_W  ALU result or effective address
- ex_alu_flags  in  3  ALU flags {N,Z,V}, i.e. {flags[2],flags[1],flags[0]}
- ex_store_data  in  DATA_W  SW data
- ex_rd  in  4  destination register
- ex_reg_write / ex_mem_read / ex_mem_write  in  1 each  controls
- id_cond  in  3  branch condition code of the instruction in ID
- mem_valid, mem_opcode, mem_alu_result, mem_store_data, mem_rd, mem_reg_write, mem_mem_read, mem_mem_write  out  (widths as EX inputs)  registered MEM-stage copies
- flags_q  out  3  architectural flags {N,Z,V}
- flags_fwd  out  3  flags as seen by ID this cycle
- cond_true  out  1  id_cond satisfied by flags_fwd

## Operation
- Accept condition: acc = ex_valid & ~stall & ~flush.
- Flag-update class by ex_opcode:
  - 0000 ADD, 0001 SUB: update N, Z and V.
  - 0010 XOR, 0100 SLL, 0101 SRA, 0110 ROR: update Z only; N and V keep their register values.
  - All other opcodes: no update.
- Candidate flag value: flags_new = merge of ex_alu_flags into flags_q according to the update class.
- Flag register: on a rising edge with acc and an updating opcode, flags_q <= flags_new; otherwise it holds.
- Forwarding (combinational): flags_fwd = flags_new when acc and the opcode updates flags; else flags_q. A branch in ID therefore sees the result of the ALU op currently in EX.
- cond_true from flags_fwd ({N,Z,V}):
  - 000 NE: ~Z
  - 001 EQ: Z
  - 010 GT: ~Z & ~N
  - 011 LT: N
  - 100 GE: Z | (~Z & ~N)
  - 101 LE: N | Z
  - 110 OV: V
  - 111: always 1
- MEM register, per rising edge, in priority order:
  - stall=1: hold every mem_* output. flush is ignored this cycle; the hazard unit keeps it asserted.
  - flush=1: load a bubble. mem_valid, mem_reg_write, mem_mem_read and mem_mem_write go to 0; data fields are don't-care and are driven to 0.
  - Otherwise: load all ex_* fields. When ex_valid=0, all control bits load 0.
- Invariant: mem_reg_write, mem_mem_read and mem_mem_write are never 1 while mem_valid=0.

## Timing
- Reset, asynchronous and effective immediately: flags_q = RST_FLAGS; all mem_* outputs = 0. flags_fwd and cond_true follow combinationally from flags_q.
- Reset asserted mid-stall: reset wins. Registered state clears and stays cleared until rst deasserts.
- Latency: ex_* to mem_* is 1 cycle; ALU flags to flags_q is 1 cycle; ALU flags to flags_fwd is 0 cycles.
- Stalled cycles cause no flag update and no forwarding of candidate flags (acc=0). This prevents a double update when the instruction is presented again.
- Flushed instructions never modify flags.
- Back-to-back flag-updating instructions each update flags in their own accept cycle; the last one accepted wins.

## Test plan
- Reset: assert rst asynchronously between clock edges -> flags_q=000 and mem_valid=0 immediately; with id_cond=111, cond_true=1; with id_cond=001, cond_true=0.
- Z-only update: ADD leaves flags {1,0,1}; then XOR with ex_alu_flags={0,1,0} is accepted -> flags_q={1,1,1}; a following RED (0011) with flags={0,0,0} leaves flags_q={1,1,1}.
- Forwarding: SUB in EX with ex_alu_flags={0,1,0}, flags_q={1,0,0}, id_cond=001 -> cond_true=1 in the same cycle; next cycle flags_q={0,1,0}.
- Stall: stall=1 for 3 cycles while ADD (result 0x1234, flags {0,0,1}) is in EX -> mem_* unchanged, flags_q unchanged, flags_fwd=flags_q; on stall release, mem_alu_result=0x1234 and flags_q={0,0,1} after exactly one edge.
- Flush versus stall: flush=1 with an SW in EX -> next cycle mem_valid=0, mem_mem_write=0, flags unchanged; flush=1 together with stall=1 -> MEM register holds its previous contents.
- Condition sweep: for each flags_q in {000, 001, 010, 100, 110} and each id_cond 000-111 (forwarding inactive) -> cond_true matches the table above.
